// File: rtl/osc_sup_pkg.sv
// Shared definitions for the crystal oscillator supervisor: FSM state
// encoding, the STATE port width and the default parameter values.
package osc_sup_pkg;

  localparam int unsigned STATE_W = 3;

  localparam int unsigned DEF_WIN_CYCLES    = 1024;
  localparam int unsigned DEF_CNT_W         = 11;
  localparam int unsigned DEF_EDGE_MIN      = 380;
  localparam int unsigned DEF_EDGE_MAX      = 440;
  localparam int unsigned DEF_GOOD_WINDOWS  = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 64;
  localparam int unsigned DEF_STALL_CYCLES  = 32;

  typedef enum logic [STATE_W-1:0] {
    RC_RUN  = 3'd0,
    SW_HOLD = 3'd1,
    XTL_RUN = 3'd2,
    FB_HOLD = 3'd3
  } sup_state_e;

endpackage

// File: rtl/osc_edge_meter.sv
// Crystal activity meter: synchronizes the XTLOSC/2 toggle into clk,
// counts its edges over fixed windows and watches for a stalled crystal.
//   clk, reset   : RC clock, synchronous active-high reset
//   tog          : XTLOSC/2 toggle, asynchronous to clk
//   win_done_c   : last cycle of the current window (combinational)
//   win_good_c   : edge count of the finishing window is in range (combinational)
//   stall_c      : no edge seen for STALL_CYCLES cycles (combinational)
//   edge_cnt     : edge count captured at the end of the last window
//   xtl_good     : in-range result of the last window
module osc_edge_meter
  import osc_sup_pkg::*;
#(
  parameter int unsigned WIN_CYCLES   = DEF_WIN_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned EDGE_MIN     = DEF_EDGE_MIN,
  parameter int unsigned EDGE_MAX     = DEF_EDGE_MAX,
  parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog,
  output logic             win_done_c,
  output logic             win_good_c,
  output logic             stall_c,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             xtl_good
);

  localparam int unsigned WIN_W   = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MIN   = CNT_W'(EDGE_MIN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(EDGE_MAX);

  logic               tog_meta;
  logic               tog_sync;
  logic               tog_hist;
  logic               edge_c;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_final_c;
  logic [STALL_W-1:0] stall_cnt;

  assign edge_c      = tog_sync ^ tog_hist;
  assign win_done_c  = (win_cnt == WIN_LAST);
  // Running count including this cycle's edge, saturating at all-ones.
  assign cnt_final_c = (edge_c && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  assign win_good_c  = (cnt_final_c >= CNT_MIN) && (cnt_final_c <= CNT_MAX);
  assign stall_c     = (stall_cnt == STALL_MAX);

  // Synchronizer, window/edge/stall counters and captured window result.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_meta  <= 1'b0;
      tog_sync  <= 1'b0;
      tog_hist  <= 1'b0;
      win_cnt   <= '0;
      cnt       <= '0;
      stall_cnt <= '0;
      edge_cnt  <= '0;
      xtl_good  <= 1'b0;
    end else begin
      tog_meta <= tog;
      tog_sync <= tog_meta;
      tog_hist <= tog_sync;

      win_cnt <= win_done_c ? '0 : win_cnt + WIN_W'(1);

      if (win_done_c) begin
        cnt      <= '0;
        edge_cnt <= cnt_final_c;
        xtl_good <= win_good_c;
      end else begin
        cnt <= cnt_final_c;
      end

      if (edge_c) begin
        stall_cnt <= '0;
      end else if (!stall_c) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

endmodule

// File: rtl/osc_clk_supervisor.sv
// XTLOSC supervisor: qualifies the crystal over consecutive good windows,
// switches the CCC reference to XTL with a bracketing CCC reset, and falls
// back to the RC oscillator on a bad window, a stall or software disable.
//   CLK, RESET : RC clock, synchronous active-high reset
//   XTL_TOG    : XTLOSC/2 toggle (asynchronous)
//   EN_XTL     : permission to run from XTL
//   FAULT_CLR  : one-cycle pulse clearing XTL_FAULT
//   SEL_XTL    : CCC source select, 1 = XTLOSC
//   CCC_RST    : CCC reset held during a source change
//   XTL_GOOD   : result of the last completed window
//   XTL_FAULT  : sticky fallback flag
//   EDGE_CNT   : edge count of the last window
//   STATE      : current FSM state code
module osc_clk_supervisor
  import osc_sup_pkg::*;
#(
  parameter int unsigned WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned EDGE_MIN      = DEF_EDGE_MIN,
  parameter int unsigned EDGE_MAX      = DEF_EDGE_MAX,
  parameter int unsigned GOOD_WINDOWS  = DEF_GOOD_WINDOWS,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned STALL_CYCLES  = DEF_STALL_CYCLES
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               XTL_TOG,
  input  logic               EN_XTL,
  input  logic               FAULT_CLR,
  output logic               SEL_XTL,
  output logic               CCC_RST,
  output logic               XTL_GOOD,
  output logic               XTL_FAULT,
  output logic [CNT_W-1:0]   EDGE_CNT,
  output logic [STATE_W-1:0] STATE
);

  localparam int unsigned GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned HOLD_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(GOOD_WINDOWS);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(SETTLE_CYCLES - 1);

  sup_state_e        state;
  sup_state_e        state_next;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_cnt_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              fault_set_c;
  logic              sel_next;
  logic              rst_next;
  logic              win_done_c;
  logic              win_good_c;
  logic              stall_c;

  osc_edge_meter #(
    .WIN_CYCLES  (WIN_CYCLES),
    .CNT_W       (CNT_W),
    .EDGE_MIN    (EDGE_MIN),
    .EDGE_MAX    (EDGE_MAX),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_meter (
    .clk       (CLK),
    .reset     (RESET),
    .tog       (XTL_TOG),
    .win_done_c(win_done_c),
    .win_good_c(win_good_c),
    .stall_c   (stall_c),
    .edge_cnt  (EDGE_CNT),
    .xtl_good  (XTL_GOOD)
  );

  assign STATE = STATE_W'(state);

  // State, counters and registered source-control outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RC_RUN;
      good_cnt  <= '0;
      hold_cnt  <= '0;
      SEL_XTL   <= 1'b0;
      CCC_RST   <= 1'b0;
      XTL_FAULT <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      hold_cnt <= hold_cnt_next;
      SEL_XTL  <= sel_next;
      CCC_RST  <= rst_next;
      // A fault set outranks a coincident clear.
      if (fault_set_c) begin
        XTL_FAULT <= 1'b1;
      end else if (FAULT_CLR) begin
        XTL_FAULT <= 1'b0;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next    = state;
    good_cnt_next = '0;
    hold_cnt_next = '0;
    fault_set_c   = 1'b0;

    case (state)
      RC_RUN: begin
        good_cnt_next = good_cnt;
        if (win_done_c) begin
          if (!win_good_c) begin
            good_cnt_next = '0;
          end else if (good_cnt != GOOD_TARGET) begin
            good_cnt_next = good_cnt + GOOD_W'(1);
          end
        end
        if ((good_cnt == GOOD_TARGET) && EN_XTL) begin
          state_next = SW_HOLD;
        end
      end
      SW_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = XTL_RUN;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end
      XTL_RUN: begin
        // Bad window or stall is a fault even when EN_XTL drops together.
        fault_set_c = (win_done_c && !win_good_c) || stall_c;
        if (fault_set_c || !EN_XTL) begin
          state_next = FB_HOLD;
        end
      end
      FB_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = RC_RUN;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_next = RC_RUN;
      end
    endcase

    // Select follows the state; reset brackets every source change.
    sel_next = (state_next == SW_HOLD) || (state_next == XTL_RUN);
    rst_next = (state_next == SW_HOLD) || (state_next == FB_HOLD);
  end

endmodule

// File: tb/tb_osc_clk_supervisor.sv
// Self-checking bench for osc_clk_supervisor: a cycle-level reference model
// built from the window/stall/qualification rules is compared every cycle,
// plus table vectors and hand-written corner sequences.
module tb_osc_clk_supervisor;

  localparam int WIN    = 1024;
  localparam int EMIN   = 380;
  localparam int EMAX   = 440;
  localparam int NGOOD  = 4;
  localparam int SETTLE = 64;
  localparam int STALL  = 32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        XTL_TOG;
  logic        EN_XTL;
  logic        FAULT_CLR;
  logic        SEL_XTL;
  logic        CCC_RST;
  logic        XTL_GOOD;
  logic        XTL_FAULT;
  logic [10:0] EDGE_CNT;
  logic [2:0]  STATE;

  int checks = 0;
  int errors = 0;

  osc_clk_supervisor dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .XTL_TOG  (XTL_TOG),
    .EN_XTL   (EN_XTL),
    .FAULT_CLR(FAULT_CLR),
    .SEL_XTL  (SEL_XTL),
    .CCC_RST  (CCC_RST),
    .XTL_GOOD (XTL_GOOD),
    .XTL_FAULT(XTL_FAULT),
    .EDGE_CNT (EDGE_CNT),
    .STATE    (STATE)
  );

  always #10 CLK = ~CLK;

  // Toggle generator: fractional rate rate_num/rate_den toggles per cycle.
  int rate_num = 0;
  int rate_den = 1;
  int acc      = 0;
  bit frozen   = 1'b0;
  bit toggled  = 1'b0;

  // Reference model state.
  bit in_hist[$];
  int m_cyc, m_last_edge, m_wcount, m_state, m_streak, m_hold, m_edge;
  bit m_good, m_fault;

  function automatic bit in_at(input int k);
    return (k < 0) ? 1'b0 : in_hist[k];
  endfunction

  // One clock of the model, using the inputs sampled at this edge.
  task automatic model_step(input bit rst, input bit tog, input bit en, input bit clr);
    bit ev, stall, done, wgood, cause, set;
    if (rst) begin
      in_hist.delete();
      m_cyc = 0; m_last_edge = -1; m_wcount = 0; m_state = 0;
      m_streak = 0; m_hold = 0; m_edge = 0; m_good = 0; m_fault = 0;
      return;
    end
    in_hist.push_back(tog);
    // An input change becomes a counted edge two samples later.
    ev    = in_at(m_cyc - 2) ^ in_at(m_cyc - 3);
    stall = (m_cyc - 1 - m_last_edge) >= STALL;
    if (ev) m_last_edge = m_cyc;
    m_wcount += int'(ev);
    done  = (m_cyc % WIN) == (WIN - 1);
    wgood = (m_wcount >= EMIN) && (m_wcount <= EMAX);
    set   = 1'b0;
    case (m_state)
      0: begin
        if (m_streak == NGOOD && en) begin m_state = 1; m_hold = SETTLE; end
        if (done) m_streak = wgood ? ((m_streak < NGOOD) ? m_streak + 1 : NGOOD) : 0;
      end
      1: begin
        m_hold--;
        if (m_hold == 0) m_state = 2;
      end
      2: begin
        cause = (done && !wgood) || stall;
        set   = cause;
        if (cause || !en) begin m_state = 3; m_hold = SETTLE; end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) begin m_state = 0; m_streak = 0; end
      end
    endcase
    if (set) m_fault = 1'b1;
    else if (clr) m_fault = 1'b0;
    if (done) begin m_edge = m_wcount; m_good = wgood; m_wcount = 0; end
    m_cyc++;
  endtask

  task automatic tick();
    logic [17:0] got, exp;
    bit sel, rst;
    @(posedge CLK);
    model_step(RESET, XTL_TOG, EN_XTL, FAULT_CLR);
    #1;
    sel = (m_state == 1) || (m_state == 2);
    rst = (m_state == 1) || (m_state == 3);
    got = {STATE, SEL_XTL, CCC_RST, XTL_GOOD, XTL_FAULT, EDGE_CNT};
    exp = {3'(m_state), sel, rst, m_good, m_fault, 11'(m_edge)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_model cyc=%0d got st/sel/rst/good/flt/cnt=%0d/%b/%b/%b/%b/%0d exp %0d/%b/%b/%b/%b/%0d",
               m_cyc, got[17:15], got[14], got[13], got[12], got[11], got[10:0],
               exp[17:15], exp[14], exp[13], exp[12], exp[11], exp[10:0]);
    end
    toggled = 1'b0;
    if (!frozen) begin
      acc += rate_num;
      if (acc >= rate_den) begin
        acc -= rate_den;
        XTL_TOG = ~XTL_TOG;
        toggled = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic set_rate(input int num, input int den);
    rate_num = num;
    rate_den = den;
    frozen   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; XTL_TOG = 1'b0; EN_XTL = 1'b0; FAULT_CLR = 1'b0;
    acc = 0; set_rate(0, 1);
    tick(); tick();
    RESET = 1'b0;
  endtask

  typedef struct {
    int num; int den; bit en; int ncyc;
    int st; bit sel; bit rst; bit good; bit fault; int elo; int ehi;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{2, 5, 1'b1, 4096, 0, 1'b0, 1'b0, 1'b1, 1'b0, 409, 410};
    vecs[1] = '{2, 5, 1'b1, 4097, 1, 1'b1, 1'b1, 1'b1, 1'b0, 409, 410};
    vecs[2] = '{2, 5, 1'b1, 4160, 1, 1'b1, 1'b1, 1'b1, 1'b0, 409, 410};
    vecs[3] = '{2, 5, 1'b1, 4161, 2, 1'b1, 1'b0, 1'b1, 1'b0, 409, 410};
    vecs[4] = '{12, 25, 1'b1, 3072, 0, 1'b0, 1'b0, 1'b0, 1'b0, 491, 492};
    vecs[5] = '{2, 5, 1'b0, 5120, 0, 1'b0, 1'b0, 1'b1, 1'b0, 409, 410};
    vecs[6] = '{0, 1, 1'b1, 2048, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

    // Reset state.
    do_reset();
    check("reset_state", int'(STATE), 0);
    check("reset_sel", int'(SEL_XTL), 0);
    check("reset_edge_cnt", int'(EDGE_CNT), 0);

    // Table vectors, each from reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      set_rate(vecs[i].num, vecs[i].den);
      EN_XTL = vecs[i].en;
      repeat (vecs[i].ncyc) tick();
      check($sformatf("vec%0d_state", i), int'(STATE), vecs[i].st);
      check($sformatf("vec%0d_sel", i), int'(SEL_XTL), int'(vecs[i].sel));
      check($sformatf("vec%0d_ccc_rst", i), int'(CCC_RST), int'(vecs[i].rst));
      check($sformatf("vec%0d_good", i), int'(XTL_GOOD), int'(vecs[i].good));
      check($sformatf("vec%0d_fault", i), int'(XTL_FAULT), int'(vecs[i].fault));
      check_range($sformatf("vec%0d_edge_cnt", i), int'(EDGE_CNT), vecs[i].elo, vecs[i].ehi);
    end

    // Stall fallback with a coincident FAULT_CLR, then a lone clear.
    do_reset();
    set_rate(2, 5); EN_XTL = 1'b1;
    repeat (4161 + 200) tick();
    check("stall_pre_state", int'(STATE), 2);
    n = 0;
    while (!toggled && n < 20) begin tick(); n++; end
    frozen = 1'b1;
    repeat (35) tick();
    check("stall_not_yet", int'(STATE), 2);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    check("stall_fb_state", int'(STATE), 3);
    check("stall_fb_sel", int'(SEL_XTL), 0);
    check("stall_fb_ccc_rst", int'(CCC_RST), 1);
    check("stall_fb_fault_set_wins", int'(XTL_FAULT), 1);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!CCC_RST) break;
      n++;
    end
    check("fb_ccc_rst_len", n, SETTLE);
    check("fb_back_to_rc", int'(STATE), 0);
    check("fb_fault_sticky", int'(XTL_FAULT), 1);
    repeat (5) tick();
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    check("lone_fault_clr", int'(XTL_FAULT), 0);

    // Three good, one bad, four good windows.
    do_reset();
    set_rate(2, 5); EN_XTL = 1'b1;
    repeat (3 * WIN) tick();
    set_rate(12, 25);
    repeat (WIN) tick();
    check("bad_window_good", int'(XTL_GOOD), 0);
    set_rate(2, 5);
    repeat (4 * WIN) tick();
    check("requal_not_yet", int'(STATE), 0);
    tick();
    check("requal_switch", int'(STATE), 1);
    check("requal_sel", int'(SEL_XTL), 1);

    // RESET in the middle of SW_HOLD.
    do_reset();
    set_rate(2, 5); EN_XTL = 1'b1;
    repeat (4097 + 29) tick();
    check("midhold_state", int'(STATE), 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midhold_rst_state", int'(STATE), 0);
    check("midhold_rst_sel", int'(SEL_XTL), 0);
    check("midhold_rst_ccc", int'(CCC_RST), 0);
    check("midhold_rst_edge", int'(EDGE_CNT), 0);

    // Randomized segments against the model.
    do_reset();
    set_rate(2, 5); EN_XTL = 1'b1;
    repeat (4500) tick();
    for (int s = 0; s < 12; s++) begin
      int pick, len;
      pick = $urandom_range(0, 5);
      case (pick)
        0: set_rate(2, 5);
        1: set_rate(12, 25);
        2: set_rate(0, 1);
        3: set_rate(21, 50);
        4: set_rate(43, 100);
        default: set_rate(371, 1000);
      endcase
      EN_XTL = ($urandom_range(0, 3) != 0);
      len = $urandom_range(300, 1800);
      for (int c = 0; c < len; c++) begin
        FAULT_CLR = ($urandom_range(0, 199) == 0);
        tick();
      end
      FAULT_CLR = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
